bmain_arbiter: RTL and testbench
================================

BMAIN_ARBITER -- requirements
Module: bmain_arbiter
Interface
REQ-001 TIMEOUT, 16'd255, stalled-cycle limit per transaction phase before a synthesized error; 0 disables.
REQ-002 clk_core  in  1  core clock; one clock for the whole block.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 fe1_cvalid  in  1  fetch1 command request; fetch1 commands are always reads.
REQ-005 bmain_cready_fe1  out  1  fetch1 command accepted.
REQ-006 fe1_addr  in  27  fetch1 word address [28:2].
REQ-007 fe1_rready  in  1  fetch1 ready for read data.
REQ-008 bmain_rvalid_fe1  out  1  read beat valid for fetch1.
REQ-009 bmain_error_fe1  out  1  bus error for fetch1 transaction.
REQ-010 fe1_eack  in  1  fetch1 error acknowledge.
REQ-011 mem1_cvalid  in  1  memory1 command request.
REQ-012 bmain_cready_mem1  out  1  memory1 command accepted.
REQ-013 mem1_cmd  in  1  memory1 command; 1=read, 0=write.
REQ-014 mem1_addr  in  27  memory1 word address [28:2].
REQ-015 mem1_rready  in  1  memory1 ready for read data.
REQ-016 bmain_rvalid_mem1  out  1  read beat valid for memory1.
REQ-017 mem1_wvalid  in  1  memory1 write data valid; writes are single-beat.
REQ-018 bmain_wready_mem1  out  1  write beat accepted.
REQ-019 mem1_wdata  in  32  memory1 write data.
REQ-020 bmain_error_mem1  out  1  bus error for memory1 transaction.
REQ-021 mem1_eack  in  1  memory1 error acknowledge.
REQ-022 bmain_cvalid / bmain_cmd / bmain_addr  out  1/1/27  command to the bus.
REQ-023 bus_cready  in  1  bus accepts command.
REQ-024 bus_rvalid / bus_rlast  in  1/1  read beat valid / last beat; rdata is routed by the top level to both requesters.
REQ-025 bmain_rready  out  1  read-beat ready to the bus.
REQ-026 bmain_wvalid / bmain_wdata  out  1/32  write beat to the bus.
REQ-027 bus_wready  in  1  bus accepts write beat.
REQ-028 bus_error / bmain_eack  in/out  1/1  bus error pulse / acknowledge to the bus.
Function
REQ-029 States: IDLE, CMD, RDATA, WDATA, ERR; an owner register (fe1/mem1) and a last-granted register (lg) accompany the state.
REQ-030 Arbitration in IDLE:
- single cvalid -> that requester is granted.
- both cvalid -> the requester != lg is granted.
- The grant registers owner, sets lg=owner, and moves to CMD on the next edge.
- No bus output asserts in IDLE, so command latency is 1 cycle.
REQ-031 CMD state:
- bmain_cvalid = owner cvalid; bmain_cmd = owner cmd (1 for fe1); bmain_addr = owner addr.
- bmain_cready_owner = bus_cready.
- On handshake: read -> RDATA, write -> WDATA.
- Owner dropping cvalid before handshake -> IDLE, with no error.
REQ-032 RDATA state:
- bmain_rready = owner rready; bmain_rvalid_owner = bus_rvalid.
- The handshake beat with bus_rlast=1 -> IDLE.
REQ-033 WDATA state:
- bmain_wvalid = mem1_wvalid; bmain_wdata = mem1_wdata; bmain_wready_mem1 = bus_wready.
- Handshake -> IDLE.
REQ-034 Every non-owner cready/rvalid/wready/error output and every unused bus output SHALL be 0.
REQ-035 Bus error in CMD/RDATA/WDATA:
- bmain_error_owner = 1 in the same cycle.
- bmain_eack = owner eack.
- Owner eack in the same cycle -> IDLE; otherwise -> ERR.
- ERR holds bmain_error_owner = 1 until owner eack, then -> IDLE.
REQ-036 Timeout counter (16-bit):
- Clears on any state change or handshake.
- Increments each stalled cycle in CMD/RDATA/WDATA, saturating.
- Reaching TIMEOUT (non-zero) -> ERR with bmain_error_owner = 1; bmain_eack stays 0 for a synthesized error.
REQ-037 Transaction end and a new request in the same cycle:
- The new request waits for the IDLE cycle, giving a minimum 1-cycle gap.
- lg changes only at grant.
Reset
REQ-038 reset_n low SHALL asynchronously force state=IDLE, owner=fe1, lg=fe1 (mem1 wins the first tie), counter=0; all outputs are 0.
REQ-039 Reset mid-transaction SHALL abandon it without error pulses; bus-side recovery is the interconnect's responsibility.
Verification
REQ-040 fe1_cvalid alone, fe1_addr=27'h0000100, bus_cready on 2nd CMD cycle, 4 beats with rlast on the 4th -> bmain_cvalid 1 cycle after request, bmain_addr=27'h0000100, 4 bmain_rvalid_fe1 pulses, IDLE after the 4th beat.
REQ-041 Both request in the first cycle after reset -> mem1 granted; after its rlast, fe1 granted; both again -> mem1 granted.
REQ-042 mem1 write mem1_wdata=32'hDEADBEEF, bus_wready low 3 cycles -> bmain_wdata stable at DEADBEEF, bmain_wready_mem1 pulses once, then IDLE.
REQ-043 bus_error on 2nd fe1 read beat with fe1_eack=1 same cycle, mem1_cvalid pending -> bmain_error_fe1=1 and bmain_eack=1 that cycle, IDLE, then mem1 granted.
REQ-044 TIMEOUT=8, bus_cready held 0 -> bmain_error_fe1 asserts after 8 stalled cycles and holds until fe1_eack; bmain_eack stays 0 throughout.
REQ-045 reset_n low during RDATA -> all outputs 0 immediately; state IDLE on release.

Source files
------------

// File: rtl/bmain_arbiter.sv
// Two-requester bus master arbiter (fetch1 / memory1) with alternating
// tie-break, bus error relay and a per-phase stall timeout.
module bmain_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        fe1_cvalid,
    output logic        bmain_cready_fe1,
    input  logic [26:0] fe1_addr,
    input  logic        fe1_rready,
    output logic        bmain_rvalid_fe1,
    output logic        bmain_error_fe1,
    input  logic        fe1_eack,
    input  logic        mem1_cvalid,
    output logic        bmain_cready_mem1,
    input  logic        mem1_cmd,
    input  logic [26:0] mem1_addr,
    input  logic        mem1_rready,
    output logic        bmain_rvalid_mem1,
    input  logic        mem1_wvalid,
    output logic        bmain_wready_mem1,
    input  logic [31:0] mem1_wdata,
    output logic        bmain_error_mem1,
    input  logic        mem1_eack,
    output logic        bmain_cvalid,
    output logic        bmain_cmd,
    output logic [26:0] bmain_addr,
    input  logic        bus_cready,
    input  logic        bus_rvalid,
    input  logic        bus_rlast,
    output logic        bmain_rready,
    output logic        bmain_wvalid,
    output logic [31:0] bmain_wdata,
    input  logic        bus_wready,
    input  logic        bus_error,
    output logic        bmain_eack
);

    typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, ERR} state_t;

    state_t      state, state_nx;
    logic        owner, owner_nx;   // 0 = fe1, 1 = mem1
    logic        lg, lg_nx;
    logic        err_syn, err_syn_nx;
    logic [15:0] cnt, cnt_nx, cnt_inc;

    logic        o_cvalid, o_cmd, o_rready, o_eack;
    logic [26:0] o_addr;
    logic        hs, busy, tmo;
    logic        x_cready, x_rvalid, x_wready, x_error;

    assign o_cvalid = owner ? mem1_cvalid : fe1_cvalid;
    assign o_cmd    = owner ? mem1_cmd    : 1'b1;
    assign o_addr   = owner ? mem1_addr   : fe1_addr;
    assign o_rready = owner ? mem1_rready : fe1_rready;
    assign o_eack   = owner ? mem1_eack   : fe1_eack;

    assign busy    = (state == CMD) || (state == RDATA) || (state == WDATA);
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign tmo     = (TIMEOUT != 16'd0) && (cnt_inc == TIMEOUT);

    always_comb begin
        hs = 1'b0;
        unique case (state)
            CMD:     hs = o_cvalid & bus_cready;
            RDATA:   hs = bus_rvalid & o_rready;
            WDATA:   hs = mem1_wvalid & bus_wready;
            default: hs = 1'b0;
        endcase
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            lg      <= 1'b0;
            err_syn <= 1'b0;
            cnt     <= 16'd0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            lg      <= lg_nx;
            err_syn <= err_syn_nx;
            cnt     <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        lg_nx      = lg;
        err_syn_nx = err_syn;
        unique case (state)
            IDLE: begin
                if (fe1_cvalid | mem1_cvalid) begin
                    owner_nx = (fe1_cvalid & mem1_cvalid) ? ~lg : mem1_cvalid;
                    lg_nx    = owner_nx;
                    state_nx = CMD;
                end
            end
            CMD, RDATA, WDATA: begin
                if (bus_error) begin
                    err_syn_nx = 1'b0;
                    state_nx   = o_eack ? IDLE : ERR;
                end else if (hs) begin
                    if (state == CMD)
                        state_nx = o_cmd ? RDATA : WDATA;
                    else if ((state == WDATA) || bus_rlast)
                        state_nx = IDLE;
                end else if ((state == CMD) && !o_cvalid) begin
                    state_nx = IDLE;
                end else if (tmo) begin
                    err_syn_nx = 1'b1;
                    state_nx   = ERR;
                end
            end
            ERR: begin
                if (o_eack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stall counter restarts on every phase change or completed beat.
    always_comb begin
        if ((state_nx != state) || hs)
            cnt_nx = 16'd0;
        else if (busy)
            cnt_nx = cnt_inc;
        else
            cnt_nx = cnt;
    end

    always_comb begin
        bmain_cvalid = 1'b0;
        bmain_cmd    = 1'b0;
        bmain_addr   = 27'd0;
        bmain_rready = 1'b0;
        bmain_wvalid = 1'b0;
        bmain_wdata  = 32'd0;
        bmain_eack   = 1'b0;
        x_cready     = 1'b0;
        x_rvalid     = 1'b0;
        x_wready     = 1'b0;
        x_error      = 1'b0;
        unique case (state)
            CMD: begin
                bmain_cvalid = o_cvalid;
                bmain_cmd    = o_cmd;
                bmain_addr   = o_addr;
                x_cready     = bus_cready;
            end
            RDATA: begin
                bmain_rready = o_rready;
                x_rvalid     = bus_rvalid;
            end
            WDATA: begin
                bmain_wvalid = mem1_wvalid;
                bmain_wdata  = mem1_wdata;
                x_wready     = bus_wready;
            end
            ERR: begin
                x_error    = 1'b1;
                bmain_eack = o_eack & ~err_syn;
            end
            default: ;
        endcase
        if (busy && bus_error) begin
            x_error    = 1'b1;
            bmain_eack = o_eack;
        end
    end

    assign bmain_cready_fe1  = ~owner & x_cready;
    assign bmain_cready_mem1 =  owner & x_cready;
    assign bmain_rvalid_fe1  = ~owner & x_rvalid;
    assign bmain_rvalid_mem1 =  owner & x_rvalid;
    assign bmain_wready_mem1 =  owner & x_wready;
    assign bmain_error_fe1   = ~owner & x_error;
    assign bmain_error_mem1  =  owner & x_error;

endmodule

// File: tb/tb_bmain_arbiter.sv
// Bench for bmain_arbiter: directed protocol scenarios plus randomized
// traffic checked by a queue-based scoreboard and monitor.
module tb_bmain_arbiter;

    logic        clk_core, reset_n;
    logic        fe1_cvalid, fe1_rready, fe1_eack;
    logic [26:0] fe1_addr;
    logic        mem1_cvalid, mem1_cmd, mem1_rready, mem1_wvalid, mem1_eack;
    logic [26:0] mem1_addr;
    logic [31:0] mem1_wdata;
    logic        bus_cready, bus_rvalid, bus_rlast, bus_wready, bus_error;
    logic        bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1;
    logic        bmain_cready_mem1, bmain_rvalid_mem1, bmain_wready_mem1;
    logic        bmain_error_mem1;
    logic        bmain_cvalid, bmain_cmd, bmain_rready, bmain_wvalid, bmain_eack;
    logic [26:0] bmain_addr;
    logic [31:0] bmain_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          own;
        bit          cmd;
        logic [26:0] addr;
        logic [31:0] wdata;
    } entry_t;

    entry_t sbq[$];
    entry_t me;
    bit     rnd_on = 1'b0;
    bit     cur_own;
    logic [31:0] cur_wd;

    bmain_arbiter #(.TIMEOUT(16'd8)) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .fe1_cvalid(fe1_cvalid), .bmain_cready_fe1(bmain_cready_fe1),
        .fe1_addr(fe1_addr), .fe1_rready(fe1_rready),
        .bmain_rvalid_fe1(bmain_rvalid_fe1), .bmain_error_fe1(bmain_error_fe1),
        .fe1_eack(fe1_eack),
        .mem1_cvalid(mem1_cvalid), .bmain_cready_mem1(bmain_cready_mem1),
        .mem1_cmd(mem1_cmd), .mem1_addr(mem1_addr), .mem1_rready(mem1_rready),
        .bmain_rvalid_mem1(bmain_rvalid_mem1), .mem1_wvalid(mem1_wvalid),
        .bmain_wready_mem1(bmain_wready_mem1), .mem1_wdata(mem1_wdata),
        .bmain_error_mem1(bmain_error_mem1), .mem1_eack(mem1_eack),
        .bmain_cvalid(bmain_cvalid), .bmain_cmd(bmain_cmd),
        .bmain_addr(bmain_addr), .bus_cready(bus_cready),
        .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast),
        .bmain_rready(bmain_rready), .bmain_wvalid(bmain_wvalid),
        .bmain_wdata(bmain_wdata), .bus_wready(bus_wready),
        .bus_error(bus_error), .bmain_eack(bmain_eack)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1,
                 bmain_cready_mem1, bmain_rvalid_mem1, bmain_wready_mem1,
                 bmain_error_mem1, bmain_cvalid, bmain_cmd, bmain_addr,
                 bmain_rready, bmain_wvalid, bmain_wdata, bmain_eack};
    endfunction

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fe1_cvalid = 0; fe1_rready = 0; fe1_eack = 0; fe1_addr = '0;
        mem1_cvalid = 0; mem1_cmd = 0; mem1_rready = 0; mem1_wvalid = 0;
        mem1_eack = 0; mem1_addr = '0; mem1_wdata = '0;
        bus_cready = 0; bus_rvalid = 0; bus_rlast = 0; bus_wready = 0;
        bus_error = 0;
        repeat (2) @(posedge clk_core);
        #1;
        chk("reset_outs", any_out(), 0);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every bus-side handshake is checked against the
    // transaction order predicted by the reference model.
    always @(negedge clk_core) begin
        if (rnd_on) begin
            if (bmain_cvalid && bus_cready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    me = sbq.pop_front();
                    cur_own = me.own;
                    cur_wd  = me.wdata;
                    chk("sb_cmd",
                        {bmain_cready_mem1, bmain_cready_fe1, bmain_cmd,
                         bmain_addr, bmain_error_fe1, bmain_error_mem1},
                        {me.own, ~me.own, me.cmd, me.addr, 2'b00});
                end
            end
            if (bus_rvalid && bmain_rready)
                chk("sb_rbeat",
                    {bmain_rvalid_mem1, bmain_rvalid_fe1, bmain_error_fe1,
                     bmain_error_mem1, bmain_eack},
                    {cur_own, ~cur_own, 3'b000});
            if (bmain_wvalid && bus_wready)
                chk("sb_wbeat", {bmain_wready_mem1, cur_own, bmain_wdata},
                    {2'b11, cur_wd});
        end
    end

    int nb, guard, beats;
    logic bad, er, ea, stab, wpend, m_lg, first, wf, wm, mc;
    logic s_cmd, s_rd, s_r, s_w, s_f, s_m;
    logic [5:0] pat;
    logic [26:0] fa, ma;
    logic [31:0] wd;

    initial begin
        reset_n = 1'b0;

        // Single fetch read, 4 beats with gaps
        do_reset();
        fe1_cvalid = 1; fe1_addr = 27'h0000100;
        #1 chk("lat_idle", bmain_cvalid, 0);
        tick(); #1;
        chk("lat_cmd", {bmain_cvalid, bmain_cmd, bmain_addr}, {2'b11, 27'h0000100});
        chk("cready_wait", bmain_cready_fe1, 0);
        tick(); bus_cready = 1; #1;
        chk("cready_fe1", {bmain_cready_fe1, bmain_cready_mem1}, 2'b10);
        tick(); fe1_cvalid = 0; bus_cready = 0; fe1_rready = 1;
        nb = 0; bad = 0; pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            bus_rvalid = pat[i]; bus_rlast = (i == 5);
            #1;
            nb += int'(bmain_rvalid_fe1);
            bad |= bmain_rvalid_mem1 | ~bmain_rready;
            tick();
        end
        bus_rvalid = 0; bus_rlast = 0; #1;
        chk("rd_beats", nb, 4);
        chk("rd_route", bad, 0);
        chk("rd_idle", bmain_rready, 0);

        // Arbitration fairness
        do_reset();
        fe1_cvalid = 1; fe1_addr = 27'h111;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h222;
        tick(); #1;
        chk("arb_first", {bmain_cvalid, bmain_addr}, {1'b1, 27'h222});
        bus_cready = 1; #1;
        chk("arb_cready1", {bmain_cready_mem1, bmain_cready_fe1}, 2'b10);
        tick(); mem1_cvalid = 0; bus_cready = 0; mem1_rready = 1;
        bus_rvalid = 1; bus_rlast = 1; #1;
        chk("arb_rvalid_m", {bmain_rvalid_mem1, bmain_rvalid_fe1}, 2'b10);
        tick(); bus_rvalid = 0; bus_rlast = 0; mem1_rready = 0; #1;
        chk("arb_gap", bmain_cvalid, 0);
        tick(); #1;
        chk("arb_second", {bmain_cvalid, bmain_addr}, {1'b1, 27'h111});
        bus_cready = 1;
        tick(); fe1_cvalid = 0; bus_cready = 0; fe1_rready = 1;
        bus_rvalid = 1; bus_rlast = 1; #1;
        chk("arb_rvalid_f", {bmain_rvalid_mem1, bmain_rvalid_fe1}, 2'b01);
        tick(); bus_rvalid = 0; bus_rlast = 0; fe1_cvalid = 1; mem1_cvalid = 1;
        tick(); #1;
        chk("arb_third", {bmain_cvalid, bmain_addr}, {1'b1, 27'h222});

        // Write with wready stalls
        do_reset();
        mem1_cvalid = 1; mem1_cmd = 0; mem1_addr = 27'h2A5;
        mem1_wvalid = 1; mem1_wdata = 32'hDEADBEEF;
        tick(); bus_cready = 1; #1;
        chk("wr_cmd", {bmain_cvalid, bmain_cmd, bmain_addr, bmain_wvalid},
            {1'b1, 1'b0, 27'h2A5, 1'b0});
        tick(); mem1_cvalid = 0; bus_cready = 0;
        nb = 0; stab = 1;
        for (int i = 0; i < 4; i++) begin
            bus_wready = (i == 3);
            #1;
            stab &= bmain_wvalid && (bmain_wdata == 32'hDEADBEEF);
            nb += int'(bmain_wready_mem1);
            tick();
        end
        mem1_wvalid = 0; #1;
        nb += int'(bmain_wready_mem1);
        chk("wr_stable", stab, 1);
        chk("wr_pulse", nb, 1);

        // Bus error with same-cycle acknowledge, mem1 pending
        do_reset();
        fe1_cvalid = 1; fe1_addr = 27'h333;
        tick(); bus_cready = 1;
        tick(); fe1_cvalid = 0; bus_cready = 0; fe1_rready = 1;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h444;
        bus_rvalid = 1; #1;
        chk("err_beat1", bmain_rvalid_fe1, 1);
        tick(); bus_error = 1; fe1_eack = 1; #1;
        chk("err_pulse", {bmain_error_fe1, bmain_eack, bmain_error_mem1}, 3'b110);
        tick(); bus_error = 0; fe1_eack = 0; bus_rvalid = 0; #1;
        chk("err_idle", {bmain_error_fe1, bmain_cvalid}, 2'b00);
        tick(); #1;
        chk("err_next", {bmain_cvalid, bmain_addr}, {1'b1, 27'h444});

        // Synthesized timeout error
        do_reset();
        fe1_cvalid = 1; fe1_addr = 27'h555;
        tick();
        er = 0; ea = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            er |= bmain_error_fe1;
            ea |= bmain_eack;
            tick();
        end
        chk("tmo_early", er, 0);
        #1 chk("tmo_err", {bmain_error_fe1, bmain_error_mem1}, 2'b10);
        er = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            er &= bmain_error_fe1;
            ea |= bmain_eack;
        end
        chk("tmo_hold", er, 1);
        fe1_eack = 1; #1;
        ea |= bmain_eack;
        tick(); fe1_eack = 0; fe1_cvalid = 0; #1;
        chk("tmo_clear", bmain_error_fe1, 0);
        chk("tmo_noeack", ea, 0);

        // Asynchronous reset mid-read
        do_reset();
        fe1_cvalid = 1; fe1_addr = 27'h666;
        tick(); bus_cready = 1;
        tick(); fe1_cvalid = 0; bus_cready = 0; fe1_rready = 1; bus_rvalid = 1; #1;
        chk("pre_rst_rvalid", bmain_rvalid_fe1, 1);
        reset_n = 0; #1;
        chk("rst_async", any_out(), 0);
        tick(); bus_rvalid = 0; fe1_rready = 0; reset_n = 1; #1;
        chk("rst_idle", any_out(), 0);
        fe1_cvalid = 1; #1;
        chk("rst_idle_req", bmain_cvalid, 0);
        tick(); #1;
        chk("rst_grant", bmain_cvalid, 1);

        // Randomized traffic against the scoreboard
        do_reset();
        fe1_rready = 1; mem1_rready = 1;
        m_lg = 0; beats = 0; wpend = 0;
        rnd_on = 1;
        for (int r = 0; r < 80; r++) begin
            wf = 1'($urandom_range(0, 1));
            wm = 1'($urandom_range(0, 1));
            if (!wf && !wm) wf = 1;
            mc = 1'($urandom_range(0, 1));
            fa = 27'($urandom);
            ma = 27'($urandom);
            wd = $urandom;
            if (wf && wm) first = ~m_lg;
            else first = wm;
            for (int k = 0; k < 2; k++) begin
                if (k == 0 || (wf && wm)) begin
                    if ((k == 0) ? first : ~first)
                        sbq.push_back('{1'b1, mc, ma, mc ? 32'd0 : wd});
                    else
                        sbq.push_back('{1'b0, 1'b1, fa, 32'd0});
                end
            end
            m_lg = (wf && wm) ? ~first : first;
            tick();
            fe1_cvalid = wf; fe1_addr = fa;
            mem1_cvalid = wm; mem1_cmd = mc; mem1_addr = ma;
            mem1_wvalid = wm & ~mc; mem1_wdata = wd;
            guard = 0;
            do begin
                @(negedge clk_core);
                s_cmd = bmain_cvalid & bus_cready;
                s_rd  = bmain_cmd;
                s_r   = bus_rvalid & bmain_rready;
                s_w   = bmain_wvalid & bus_wready;
                s_f   = fe1_cvalid & bmain_cready_fe1;
                s_m   = mem1_cvalid & bmain_cready_mem1;
                @(posedge clk_core); #1;
                if (s_f) fe1_cvalid = 0;
                if (s_m) mem1_cvalid = 0;
                if (s_w) begin mem1_wvalid = 0; wpend = 0; end
                if (s_cmd) begin
                    if (s_rd) beats = $urandom_range(1, 4);
                    else wpend = 1;
                end
                if (s_r) beats--;
                bus_cready = ($urandom_range(0, 7) != 0);
                bus_wready = ($urandom_range(0, 7) != 0);
                if (!(bus_rvalid && !s_r))
                    bus_rvalid = (beats > 0) && ($urandom_range(0, 7) != 0);
                bus_rlast = (beats == 1);
                guard++;
            end while (!(sbq.size() == 0 && beats == 0 && !wpend && !fe1_cvalid
                         && !mem1_cvalid && !mem1_wvalid) && guard < 500);
            if (guard >= 500) begin
                chk("rnd_progress", guard, 0);
                break;
            end
        end
        bus_rvalid = 0; bus_rlast = 0;
        tick();
        rnd_on = 0;
        chk("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
